// File: rtl/bus_types_pkg.sv
// Shared types for the snooping bus controller: bus state encoding, RAM handshake states, word type.
package bus_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE,
    SNOOP,
    C2C,
    RAMRD,
    RAMWR,
    IFETCH
  } bus_state_t;

endpackage

// File: rtl/coherence_bus_ctrl_rr_arbiter.sv
// Round-robin picker: grants the first requesting index at or after start, wrapping modulo N.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  int pos;

  // Scan from the far end back towards start so the closest requester is written last and wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    pos   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = (int'(start) + k) % N;
      if (req[pos]) begin
        grant      = '0;
        grant[pos] = 1'b1;
        idx        = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/coherence_bus_ctrl.sv
// N-processor snooping bus controller and RAM arbiter; cache-to-cache supply is also written back to RAM.
module coherence_bus_ctrl
  import bus_types_pkg::*;
#(
  parameter int CPUS     = 4,
  parameter int BLKWORDS = 2
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [CPUS-1:0]        iREN,
  input  logic [CPUS-1:0][31:0]  iaddr,
  output logic [CPUS-1:0]        iwait,
  output logic [CPUS-1:0][31:0]  iload,
  input  logic [CPUS-1:0]        dREN,
  input  logic [CPUS-1:0]        dWEN,
  input  logic [CPUS-1:0][31:0]  daddr,
  input  logic [CPUS-1:0][31:0]  dstore,
  output logic [CPUS-1:0]        dwait,
  output logic [CPUS-1:0][31:0]  dload,
  input  logic [CPUS-1:0]        cctrans,
  input  logic [CPUS-1:0]        ccwrite,
  output logic [CPUS-1:0]        ccwait,
  output logic [CPUS-1:0]        ccinv,
  output logic [CPUS-1:0][31:0]  ccsnoopaddr,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [31:0]            ramaddr,
  output logic [31:0]            ramstore,
  input  logic [31:0]            ramload,
  input  logic [1:0]             ramstate
);

  localparam int    IW      = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int    WW      = (BLKWORDS > 1) ? $clog2(BLKWORDS) : 1;
  localparam word_t BLKMASK = ~word_t'(BLKWORDS * 4 - 1);

  bus_state_t      state, next_state;
  logic [IW-1:0]   req, sup, rr_ptr, req_nxt, rr_after;
  logic [WW-1:0]   wcnt;
  logic            isrdx, ram_ack, last_word;
  word_t           word_addr;
  logic [CPUS-1:0] wr_grant, rd_grant, if_grant, sup_grant, req_onehot, snoop_req;
  logic [IW-1:0]   wr_idx, rd_idx, if_idx, sup_idx;

  assign ram_ack    = (ramstate_t'(ramstate) == ACCESS);
  assign last_word  = (wcnt == WW'(BLKWORDS - 1));
  assign rr_after   = (req == IW'(CPUS - 1)) ? '0 : req + 1'b1;
  assign req_onehot = CPUS'(1) << req;
  assign snoop_req  = cctrans & ~req_onehot;
  assign word_addr  = (daddr[req] & BLKMASK) + (word_t'(wcnt) << 2);

  rr_arbiter #(.N(CPUS), .IW(IW)) u_wr_arb  (.req(dWEN),           .start(rr_ptr),   .grant(wr_grant),  .idx(wr_idx));
  rr_arbiter #(.N(CPUS), .IW(IW)) u_rd_arb  (.req(dREN & cctrans), .start(rr_ptr),   .grant(rd_grant),  .idx(rd_idx));
  rr_arbiter #(.N(CPUS), .IW(IW)) u_if_arb  (.req(iREN),           .start(rr_ptr),   .grant(if_grant),  .idx(if_idx));
  rr_arbiter #(.N(CPUS), .IW(IW)) u_sup_arb (.req(snoop_req),      .start(rr_after), .grant(sup_grant), .idx(sup_idx));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  // Transaction bookkeeping: winner and supplier are latched once and held for the whole block.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      req    <= '0;
      sup    <= '0;
      wcnt   <= '0;
      rr_ptr <= '0;
      isrdx  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          wcnt  <= '0;
          req   <= req_nxt;
          isrdx <= ccwrite[req_nxt];
        end
        SNOOP: sup <= sup_idx;
        C2C, RAMRD, RAMWR: begin
          if (ram_ack) begin
            wcnt <= wcnt + 1'b1;
            if (last_word) rr_ptr <= rr_after;
          end
        end
        IFETCH: if (ram_ack) rr_ptr <= rr_after;
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state = state;
    req_nxt    = if_idx;
    unique case (state)
      IDLE: begin
        if (|wr_grant) begin
          next_state = RAMWR;
          req_nxt    = wr_idx;
        end else if (|rd_grant) begin
          next_state = SNOOP;
          req_nxt    = rd_idx;
        end else if (|if_grant) begin
          next_state = IFETCH;
        end
      end
      SNOOP:             next_state = (|sup_grant) ? C2C : RAMRD;
      C2C, RAMRD, RAMWR: if (ram_ack && last_word) next_state = IDLE;
      IFETCH:            if (ram_ack) next_state = IDLE;
      default:           next_state = IDLE;
    endcase
  end

  // Everything visible on the bus is decoded from state so a reset drops it immediately.
  always_comb begin
    iwait       = '1;
    dwait       = '1;
    iload       = '0;
    dload       = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    unique case (state)
      SNOOP: begin
        for (int i = 0; i < CPUS; i++) begin
          if (i != int'(req)) begin
            ccwait[i]      = 1'b1;
            ccinv[i]       = isrdx;
            ccsnoopaddr[i] = daddr[req];
          end
        end
      end
      C2C: begin
        ccwait           = ~req_onehot;
        ccsnoopaddr[sup] = word_addr;
        dload[req]       = dstore[sup];
        ramWEN           = 1'b1;
        ramaddr          = word_addr;
        ramstore         = dstore[sup];
        dwait[req]       = ~ram_ack;
      end
      RAMRD: begin
        ramREN     = 1'b1;
        ramaddr    = word_addr;
        dload[req] = ramload;
        dwait[req] = ~ram_ack;
      end
      RAMWR: begin
        ramWEN     = 1'b1;
        ramaddr    = word_addr;
        ramstore   = dstore[req];
        dwait[req] = ~ram_ack;
      end
      IFETCH: begin
        ramREN     = 1'b1;
        ramaddr    = iaddr[req];
        iload[req] = ramload;
        iwait[req] = ~ram_ack;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Self-checking bench for coherence_bus_ctrl against a transaction-level model of arbitration, snooping and RAM.
module tb_coherence_bus_ctrl;
  import bus_types_pkg::*;

  localparam int CPUS     = 4;
  localparam int BLKWORDS = 2;

  logic                  CLK = 1'b0;
  logic                  nRST;
  logic [CPUS-1:0]       iREN, iwait, dREN, dWEN, dwait, cctrans, ccwrite, ccwait, ccinv;
  logic [CPUS-1:0][31:0] iaddr, iload, daddr, dstore, dload, ccsnoopaddr;
  logic                  ramREN, ramWEN;
  logic [31:0]           ramaddr, ramstore, ramload;
  logic [1:0]            ramstate;

  int    n_checks = 0;
  int    n_pass   = 0;
  int    n_fail   = 0;
  int    rr_model = 0;
  word_t mem [word_t];

  coherence_bus_ctrl #(.CPUS(CPUS), .BLKWORDS(BLKWORDS)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic word_t mem_rd(input word_t a);
    return mem.exists(a) ? mem[a] : (32'hDEAD0000 | {16'h0, a[15:0]});
  endfunction

  function automatic int pick(input logic [CPUS-1:0] v, input int ptr);
    for (int k = 0; k < CPUS; k++)
      if (v[(ptr + k) % CPUS]) return (ptr + k) % CPUS;
    return -1;
  endfunction

  function automatic int model_winner();
    if (dWEN != 0)             return pick(dWEN, rr_model);
    if ((dREN & cctrans) != 0) return pick(dREN & cctrans, rr_model);
    return pick(iREN, rr_model);
  endfunction

  task automatic clear_data_side();
    dWEN = '0; dREN = '0; cctrans = '0; ccwrite = '0;
  endtask

  // One block transaction: write-back (rd=0) or read miss (rd=1) with optional responder s.
  task automatic data_txn(input bit rd, input int r, input int s, input word_t addr, input bit rdx,
                          input int stall, input logic [1:0] stall_st, input word_t seed);
    int              w_exp, sup_exp, nb;
    logic [CPUS-1:0] others, snoopers;
    logic [1:0]      strobes;
    bit              c2c;
    word_t           base, wa, data;
    clear_data_side();
    daddr[r] = addr;
    if (rd) begin
      dREN[r] = 1'b1; cctrans[r] = 1'b1; ccwrite[r] = rdx;
    end else dWEN[r] = 1'b1;
    if (s >= 0) begin
      cctrans[s] = 1'b1; daddr[s] = $urandom;
    end
    ramstate = FREE;
    #1;
    w_exp    = model_winner();
    others   = 4'hF & ~(4'b1 << w_exp);
    snoopers = cctrans & others;
    sup_exp  = rd ? pick(snoopers, (w_exp + 1) % CPUS) : -1;
    c2c      = rd && (sup_exp >= 0);
    strobes  = (rd && !c2c) ? 2'b10 : 2'b01;
    base     = addr & ~word_t'(BLKWORDS * 4 - 1);
    check("idle dwait", dwait, 4'hF);
    check("idle strobes", {ramREN, ramWEN}, 2'b00);
    tick();
    if (rd) begin
      check("snoop ccwait", ccwait, others);
      check("snoop ccinv", ccinv, rdx ? others : 4'h0);
      check("snoop addr", ccsnoopaddr[(w_exp + 1) % CPUS], addr);
      check("snoop strobes", {ramREN, ramWEN}, 2'b00);
      check("snoop dwait", dwait, 4'hF);
      tick();
    end
    for (int w = 0; w < BLKWORDS; w++) begin
      wa   = base + word_t'(4 * w);
      data = (seed != 0) ? seed + word_t'(w) : $urandom;
      if (c2c) dstore[sup_exp] = data;
      else if (!rd) dstore[w_exp] = data;
      nb = (w == 0) ? stall : int'($urandom_range(0, 2));
      for (int b = 0; b < nb; b++) begin
        ramstate = (w == 0) ? stall_st : 2'(BUSY);
        ramload  = $urandom;
        #1;
        check($sformatf("stall w%0d dwait", w), dwait, 4'hF);
        check($sformatf("stall w%0d addr", w), ramaddr, wa);
        check($sformatf("stall w%0d strobes", w), {ramREN, ramWEN}, strobes);
        tick();
      end
      ramstate = ACCESS;
      ramload  = (rd && !c2c) ? mem_rd(wa) : $urandom;
      #1;
      check($sformatf("ack w%0d dwait", w), dwait, others);
      check($sformatf("ack w%0d addr", w), ramaddr, wa);
      check($sformatf("ack w%0d strobes", w), {ramREN, ramWEN}, strobes);
      if (rd) check($sformatf("ack w%0d dload", w), dload[w_exp], c2c ? data : mem_rd(wa));
      if (!rd || c2c) begin
        check($sformatf("ack w%0d ramstore", w), ramstore, data);
        mem[wa] = data;
      end
      if (c2c) begin
        check($sformatf("c2c w%0d ccwait", w), ccwait, others);
        check($sformatf("c2c w%0d snoopaddr", w), ccsnoopaddr[sup_exp], wa);
      end
      tick();
    end
    rr_model = (w_exp + 1) % CPUS;
    clear_data_side();
    ramstate = FREE;
  endtask

  task automatic fetch_once();
    int    w_exp, nb;
    word_t rdata;
    ramstate = FREE;
    #1;
    w_exp = model_winner();
    check("fetch idle iwait", iwait, 4'hF);
    tick();
    nb = $urandom_range(0, 3);
    for (int b = 0; b < nb; b++) begin
      ramstate = BUSY;
      #1;
      check("fetch busy iwait", iwait, 4'hF);
      check("fetch busy addr", ramaddr, iaddr[w_exp]);
      check("fetch busy strobes", {ramREN, ramWEN}, 2'b10);
      tick();
    end
    rdata    = $urandom;
    ramstate = ACCESS;
    ramload  = rdata;
    #1;
    check("fetch ack iwait", iwait, 4'hF & ~(4'b1 << w_exp));
    check("fetch ack iload", iload[w_exp], rdata);
    check("fetch ack addr", ramaddr, iaddr[w_exp]);
    tick();
    rr_model = (w_exp + 1) % CPUS;
    ramstate = FREE;
  endtask

  initial begin
    int    r, s;
    word_t a;
    nRST = 1'b0;
    iREN = '0; iaddr = '0; dstore = '0; daddr = '0; ramload = '0; ramstate = FREE;
    clear_data_side();
    mem[32'h200] = 32'h11;
    mem[32'h204] = 32'h22;
    #2;
    check("reset iwait", iwait, 4'hF);
    check("reset dwait", dwait, 4'hF);
    check("reset ccwait", ccwait, 4'h0);
    check("reset strobes", {ramREN, ramWEN}, 2'b00);
    check("reset ramaddr", ramaddr, 32'h0);
    @(posedge CLK);
    #1;
    nRST = 1'b1;

    $display("[TB] write-back CPU2 0x104");
    data_txn(1'b0, 2, -1, 32'h104, 1'b0, 2, 2'(BUSY), 32'hAAAA0000);
    $display("[TB] BusRd CPU1 0x200, no responder");
    data_txn(1'b1, 1, -1, 32'h200, 1'b0, 1, 2'(BUSY), 32'h0);
    $display("[TB] BusRdX CPU0 0x300, CPU3 supplies");
    data_txn(1'b1, 0, 3, 32'h300, 1'b1, 1, 2'(BUSY), 32'h0);
    $display("[TB] BusRd CPU2 0x304, RAM must hold the supplied block");
    data_txn(1'b1, 2, -1, 32'h304, 1'b0, 0, 2'(BUSY), 32'h0);

    $display("[TB] CPU0 fetch vs CPU2 write-back with RAM ERROR stall");
    iREN[0]  = 1'b1;
    iaddr[0] = 32'h400;
    data_txn(1'b0, 2, -1, 32'h500, 1'b0, 5, 2'(ERROR), 32'h0);
    fetch_once();
    iREN = '0;

    $display("[TB] randomized transactions");
    for (int t = 0; t < 12; t++) begin
      r = $urandom_range(0, CPUS - 1);
      s = ($urandom_range(0, 1) == 1) ? -1 : (r + 1 + int'($urandom_range(0, CPUS - 2))) % CPUS;
      a = 32'h1000 + word_t'($urandom_range(0, 7) * 8) + word_t'($urandom_range(0, 1) * 4);
      if ($urandom_range(0, 2) == 0)
        data_txn(1'b0, r, -1, a, 1'b0, $urandom_range(0, 3), 2'(BUSY), 32'h0);
      else
        data_txn(1'b1, r, s, a, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 2'(FREE), 32'h0);
    end

    $display("[TB] reset during RAMRD");
    clear_data_side();
    dREN[1] = 1'b1; cctrans[1] = 1'b1; daddr[1] = 32'h200;
    tick();
    tick();
    ramstate = BUSY;
    #1;
    check("pre-reset ramREN", ramREN, 1'b1);
    nRST = 1'b0;
    #1;
    check("mid-reset dwait", dwait, 4'hF);
    check("mid-reset ramREN", ramREN, 1'b0);
    tick();
    check("held-reset dwait", dwait, 4'hF);
    clear_data_side();
    nRST     = 1'b1;
    rr_model = 0;
    tick();
    check("post-reset idle strobes", {ramREN, ramWEN}, 2'b00);
    check("post-reset idle ccwait", ccwait, 4'h0);

    $display("[TB] all CPUs fetching, round-robin from 0");
    for (int i = 0; i < CPUS; i++) iaddr[i] = 32'h800 + word_t'(4 * i);
    iREN = '1;
    for (int k = 0; k < 5; k++) fetch_once();
    iREN = '0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
